// File: rtl/mips_muldiv.sv
// rtl/mips_muldiv.sv - iterative MIPS multiply/divide unit owning HI/LO
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             md__start,
    input  logic [2:0]       md__op,
    input  logic [WIDTH-1:0] md__op1,
    input  logic [WIDTH-1:0] md__op2,
    input  logic             md__flush,
    output logic             md__busy,
    output logic             md__done,
    output logic             md__divZero,
    output logic [WIDTH-1:0] md__hi,
    output logic [WIDTH-1:0] md__lo
);
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
        $error("mips_muldiv: WIDTH must be even and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   op1_q;
    logic               qsign_q;
    logic               rsign_q;
    logic               is_div_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               divzero_q;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    logic op_signed;
    assign op_signed = ~md__op[0];

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_part - {1'b0, a_q};
    assign div_next = div_diff[WIDTH]
                    ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    always_comb begin
        prod_fix = qsign_q ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                fix_hi = op1_q;
                fix_lo = '1;
            end else begin
                fix_hi = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                fix_lo = qsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            acc_q     <= '0;
            op1_q     <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md__start && !md__flush) begin
                        case (md__op)
                            3'b000, 3'b001: begin
                                a_q      <= magnitude(md__op1, op_signed);
                                acc_q    <= {{WIDTH{1'b0}}, magnitude(md__op2, op_signed)};
                                qsign_q  <= op_signed & (md__op1[WIDTH-1] ^ md__op2[WIDTH-1]);
                                rsign_q  <= 1'b0;
                                is_div_q <= 1'b0;
                                dz_q     <= 1'b0;
                                cnt_q    <= CW'(WIDTH);
                                state_q  <= MUL;
                            end
                            3'b010, 3'b011: begin
                                a_q      <= magnitude(md__op2, op_signed);
                                acc_q    <= {{WIDTH{1'b0}}, magnitude(md__op1, op_signed)};
                                qsign_q  <= op_signed & (md__op1[WIDTH-1] ^ md__op2[WIDTH-1]);
                                rsign_q  <= op_signed & md__op1[WIDTH-1];
                                is_div_q <= 1'b1;
                                dz_q     <= (md__op2 == '0);
                                op1_q    <= md__op1;
                                cnt_q    <= CW'(WIDTH);
                                state_q  <= DIV;
                            end
                            3'b100: begin
                                hi_q   <= md__op1;
                                done_q <= 1'b1;
                            end
                            3'b101: begin
                                lo_q   <= md__op1;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (md__flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= (state_q == MUL) ? mul_next : div_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    if (!md__flush) begin
                        hi_q      <= fix_hi;
                        lo_q      <= fix_lo;
                        done_q    <= 1'b1;
                        divzero_q <= dz_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md__busy    = (state_q != IDLE);
    assign md__done    = done_q;
    assign md__divZero = divzero_q;
    assign md__hi      = hi_q;
    assign md__lo      = lo_q;
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised iterative multiply/divide unit owning the MIPS HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO alongside the combinational ALU in the execute stage. The multi-cycle ops use a radix-2 shift-add/restoring-divide datapath, and `md__busy` tells the pipeline to stall MFHI/MFLO and later mul/div ops until results land. The unit supports a flush that kills an in-flight op without touching HI/LO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4 and even.
- `clk` in 1: rising-edge clock.
- `rst_b` in 1: asynchronous, active-low reset.
- `md__start` in 1: request; sampled only in IDLE.
- `md__op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored (no state change).
- `md__op1` in WIDTH: rs (multiplicand / dividend / MTHI-MTLO source).
- `md__op2` in WIDTH: rt (multiplier / divisor).
- `md__flush` in 1: kill in-flight op; the pipeline squashes it.
- `md__busy` out 1: high while an iterative op is in flight.
- `md__done` out 1: one-cycle pulse after HI/LO are written by any accepted op.
- `md__divZero` out 1: valid only with `md__done`; high when the completed op was DIV/DIVU with divisor 0.
- `md__hi`, `md__lo` out WIDTH: architectural HI/LO registers.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **IDLE, start with MULT/MULTU:**
  - Latch the operand magnitudes (signed ops take two's-complement absolute value).
  - Record the result sign (op1 sign XOR op2 sign for MULT; 0 for MULTU).
  - Clear the 2·WIDTH accumulator, load the iteration counter with WIDTH, go to MUL.
- **IDLE, start with DIV/DIVU:**
  - Latch the magnitudes.
  - Quotient sign = XOR of the operand signs; remainder sign = dividend sign (0 for DIVU).
  - Load the counter with WIDTH, go to DIV.
- **IDLE, start with MTHI/MTLO:** write `md__op1` to HI or LO at that edge, stay IDLE, pulse `md__done` next cycle.
- **MUL:** one multiplier bit per cycle (add-shift). The counter decrements and goes to FIX when it hits 0.
- **DIV:** one restoring-subtract step per cycle, producing one quotient bit and a partial remainder. Goes to FIX when the counter hits 0.
- **FIX:**
  - Apply sign correction by conditional two's-complement negate of the product, quotient and remainder.
  - Write HI/LO, return to IDLE, set `md__done`.
- **Result mapping:**
  - MUL: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
  - DIV: LO = quotient (truncated toward zero), HI = remainder.
- **Arithmetic is modulo the field width.** A most-negative dividend divided by −1 yields LO = most-negative, HI = 0; no trap.
- **Divide by zero:** datapath still runs WIDTH cycles. FIX forces LO = all ones and HI = op1 as latched (signed value for DIV), with `md__divZero` = 1 alongside `md__done`.
- **Start while busy:** ignored; the pipeline must not issue it.
- **Flush:**
  - `md__flush` in MUL/DIV/FIX returns to IDLE at that edge, HI/LO unchanged, no `md__done`.
  - Flush in IDLE cancels a same-cycle start (flush wins).
- **Reset:** asynchronous `rst_b` low at any time forces IDLE with HI = LO = 0, `md__busy` = `md__done` = `md__divZero` = 0 and counter = 0. A mid-op reset discards the op.

## Timing
- Start accepted at edge E0, so `md__busy` = 1 from E0.
- Iterations occur at edges E1..E(WIDTH); FIX writes HI/LO at E(WIDTH+1).
- From E(WIDTH+1): `md__busy` = 0, `md__done` = 1 for exactly one cycle, and the new HI/LO are visible.
- Total latency is WIDTH+1 edges (33 for WIDTH=32).
- MTHI/MTLO: HI/LO update at E0, `md__done` is high in the cycle after E0, and `md__busy` never rises.
- A new start may be accepted in the same cycle `md__done` is high (state is IDLE).
- `md__busy` is a registered state decode with no combinational path from inputs. `md__hi`/`md__lo` are registered.

## Test plan
- **MULT:** MULT op1=0xFFFFFFFD (−3), op2=5 → after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFF1; `md__done` pulses once; busy high for exactly 33 cycles.
- **MULTU:** MULTU op1=op2=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **DIV signs and overflow:**
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=7, `md__divZero`=1 with `md__done`.
- **Move ops:** MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → both land in one cycle each, two done pulses, busy never asserted.
- **Flush:** with HI/LO preloaded to 0xAAAAAAAA/0x55555555, start MULT, flush at iteration 10 → IDLE, HI/LO unchanged, no done. Immediately start DIVU 100/7 → LO=14, HI=2.
- **Reset:** drop `rst_b` asynchronously mid-DIV (between edges) → outputs clear immediately. After release, a new MULTU 3×4 yields HI=0, LO=12. Repeat the MULT/DIV vectors with WIDTH=8 (e.g. MULT 0xFD×0x05 → HI=0xFF, LO=0xF1; latency 9).
